op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
- Next-generation micro-step sequencer for the SM83 core; sits between the memory data bus and the opcode decoder.
- Latches IR, tracks the CB prefix and sequences `step`, with conditional step branching.
- Adds over the current sequencer: parametrised step width, memory wait-state stalls, HALT state, interrupt dispatch with IME and EI delay, asynchronous reset.

Parameters:
STEP_W, 3, width of step counter (decoder microcode depth = 2**STEP_W)
NUM_IRQ, 5, number of interrupt sources; index 0 is highest priority
RESET_IR, 8'h00, IR value loaded at reset (NOP)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
done  in  1  decoder: current step is the last of the instruction
is_cond  in  1  decoder: branch on cond this step
cond  in  2  cond_t (NZ, Z, NC, C)
flags  in  4  flags_t {z, n, h, c}
next_cond  in  STEP_W  step to load when is_cond and cond not matched
halt_req  in  1  decoder: HALT, asserted together with done
ei_req  in  1  decoder: EI executing
di_req  in  1  decoder: DI executing
mem_ready  in  1  memory access this cycle completes; low = stall
d_in  in  8  data bus from memory
irq_pend  in  NUM_IRQ  IE & IF, level
ir  out  8  instruction register
in_prefix  out  1  IR holds a CB-page opcode
in_irq  out  1  decoder runs interrupt-dispatch microcode
irq_idx  out  $clog2(NUM_IRQ)  latched vector index
irq_ack  out  NUM_IRQ  one-hot, one-cycle pulse to clear IF bit
step  out  STEP_W  current step
halted  out  1  in HALT state
ime  out  1  interrupt master enable
no_pc_inc  out  1  HALT-bug indicator (see Optional Feature)

Behaviour:
- Reset (rst=0, async) values:
  - ir=RESET_IR, step=0, in_prefix=0, in_irq=0, halted=0, ime=0, irq_idx=0.
  - irq_ack=0, no_pc_inc=0, ime_pend=0, state=SEQ_RUN.
  - Reset mid-instruction abandons it.
- Stall: mem_ready=0 freezes every register; irq_ack=0 that cycle; done/is_cond ignored.
- matched = NZ:!z, Z:z, NC:!c, C:c.
- SEQ_RUN, priority order per edge (mem_ready=1):
  1. done=1 → step<=0, in_prefix<=0, in_irq<=0, then the first applicable of:
     - ime && |irq_pend && !in_irq → state SEQ_IRQ, in_irq<=1, ime<=0, irq_idx<=lowest set bit, irq_ack<=onehot(idx); ir unchanged.
     - halt_req → state SEQ_HALT, halted<=1.
     - otherwise ir<=d_in.
  2. ir==8'hCB && !in_prefix && !in_irq → ir<=d_in, in_prefix<=1, step<=0.
  3. is_cond && !matched → step<=next_cond.
  4. Otherwise step<=step+1.
     - step all-ones and not done is an illegal decoder program: $error in simulation, wraps to 0 in hardware.
- SEQ_IRQ is SEQ_RUN with in_irq=1; its done returns to normal fetch (ir<=d_in, in_irq<=0).
- SEQ_HALT:
  - step held 0; decoder inputs ignored.
  - On |irq_pend (regardless of ime): halted<=0.
    - If ime → dispatch as above.
    - Else → ir<=d_in, state SEQ_RUN.
- EI/DI:
  - di_req → ime<=0 and ime_pend<=0 immediately.
  - ei_req → ime_pend<=1; ime<=1 at the done of the *following* instruction, after the interrupt check on that edge.
  - ei_req and di_req together → DI wins.
- irq_ack is high exactly one cycle, on the cycle after the dispatch edge.

Optional Feature:
- Macro: SEQ_HALT_BUG_EN.
- Defined:
  - halt_req with ime=0 and |irq_pend already set → no HALT entry; ir<=d_in.
  - no_pc_inc pulses 1 for that first step, so the decoder suppresses the PC increment (opcode byte read twice).
- Undefined:
  - HALT entry occurs, and exits on the next edge via the SEQ_HALT rule.
  - no_pc_inc tied 0.

Decomposition:
- Package seq_pkg holds:
  - cond_t, flags_t
  - seq_state_t {SEQ_RUN, SEQ_HALT, SEQ_IRQ}
  - constant PREFIX_OPCODE=8'hCB
- Sub-module cond_eval(cond, flags → matched), purely combinational.
- Priority encoder is inline.

Test Plan:
- NOP stream, d_in=8'h00, mem_ready=1: done every cycle → step stays 0, ir=8'h00; reset released mid-run → all outputs at reset values.
- JR NZ (8'h20), flags.z=1, is_cond step0, next_cond=3 → step 0→3, then done → ir<=d_in; with z=0 → 0→1→2.
- CB prefix: ir=8'hCB, d_in=8'h11 → ir=8'h11, in_prefix=1, step=0; next done → in_prefix=0.
- mem_ready=0 for 3 cycles at step=1 → step, ir, ime unchanged; irq_ack stays 0.
- EI, then NOP, with irq_pend=5'b00110 → no dispatch at EI's next done; dispatch after the NOP: irq_idx=1, irq_ack=5'b00010 for one cycle, ime=0.
- HALT with ime=0, irq_pend=0 → halted=1; raise irq_pend=5'b10000 → halted=0, ir<=d_in, no dispatch. With SEQ_HALT_BUG_EN and irq already pending → no halt, no_pc_inc=1 for one step.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the SM83 micro-step sequencer.
package seq_pkg;

   typedef enum logic [1:0] {COND_NZ, COND_Z, COND_NC, COND_C} cond_t;

   typedef struct packed {
      logic z;
      logic n;
      logic h;
      logic c;
   } flags_t;

   typedef enum logic [1:0] {SEQ_RUN, SEQ_HALT, SEQ_IRQ} seq_state_t;

   localparam logic [7:0] PREFIX_OPCODE = 8'hCB;

endpackage

// File: rtl/op_sequencer_if.sv
// Decoder/memory-side bundle of the op_sequencer; master drives decoder and bus inputs,
// slave is the sequencer itself.
interface op_sequencer_if #(
   parameter int unsigned STEP_W  = 3,
   parameter int unsigned NUM_IRQ = 5,
   parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) ();
   import seq_pkg::*;

   logic               done;
   logic               is_cond;
   cond_t              cond;
   flags_t             flags;
   logic [STEP_W-1:0]  next_cond;
   logic               halt_req;
   logic               ei_req;
   logic               di_req;
   logic               mem_ready;
   logic [7:0]         d_in;
   logic [NUM_IRQ-1:0] irq_pend;

   logic [7:0]         ir;
   logic               in_prefix;
   logic               in_irq;
   logic [IDX_W-1:0]   irq_idx;
   logic [NUM_IRQ-1:0] irq_ack;
   logic [STEP_W-1:0]  step;
   logic               halted;
   logic               ime;
   logic               no_pc_inc;

   modport master (
      output done, is_cond, cond, flags, next_cond, halt_req, ei_req, di_req,
             mem_ready, d_in, irq_pend,
      input  ir, in_prefix, in_irq, irq_idx, irq_ack, step, halted, ime, no_pc_inc
   );

   modport slave (
      input  done, is_cond, cond, flags, next_cond, halt_req, ei_req, di_req,
             mem_ready, d_in, irq_pend,
      output ir, in_prefix, in_irq, irq_idx, irq_ack, step, halted, ime, no_pc_inc
   );

endinterface

// File: rtl/cond_eval.sv
// Branch-condition evaluator: does the flag state satisfy the decoder's cond code.
module cond_eval
   import seq_pkg::*;
(
   input  cond_t  i_cond,
   input  flags_t i_flags,
   output logic   o_matched
);

   logic w_unused;
   assign w_unused = i_flags.n ^ i_flags.h;

   always_comb begin
      o_matched = 1'b0;
      unique case (i_cond)
         COND_NZ: o_matched = !i_flags.z;
         COND_Z:  o_matched = i_flags.z;
         COND_NC: o_matched = !i_flags.c;
         COND_C:  o_matched = i_flags.c;
      endcase
   end

endmodule

// File: rtl/op_sequencer.sv
// Micro-step sequencer between the memory data bus and the SM83 opcode decoder.
// Define SEQ_HALT_BUG_EN to model the HALT-with-pending-IRQ opcode double read.
module op_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned STEP_W   = 3,
   parameter int unsigned NUM_IRQ  = 5,
   parameter logic [7:0]  RESET_IR = 8'h00
) (
   input logic           clk,
   input logic           rst_n,
   op_sequencer_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   seq_state_t         r_state, w_state_d;
   logic [7:0]         r_ir, w_ir_d;
   logic [STEP_W-1:0]  r_step, w_step_d;
   logic               r_prefix, w_prefix_d;
   logic [IDX_W-1:0]   r_idx, w_idx_d, w_lowest;
   logic [NUM_IRQ-1:0] r_ack, w_ack_d;
   logic               r_ime, w_ime_d;
   logic               r_ime_pend, w_ime_pend_d;
   logic               r_no_pc_inc, w_no_pc_inc_d;
   logic               w_matched, w_irq_any, w_in_irq, w_halt_bug, w_prefix_hit, w_branch;

   cond_eval u_cond_eval (
      .i_cond    (bus.cond),
      .i_flags   (bus.flags),
      .o_matched (w_matched)
   );

   assign w_irq_any    = |bus.irq_pend;
   assign w_in_irq     = (r_state == SEQ_IRQ);
   assign w_prefix_hit = (r_ir == PREFIX_OPCODE) && !r_prefix && !w_in_irq;
   assign w_branch     = bus.is_cond && !w_matched;

`ifdef SEQ_HALT_BUG_EN
   assign w_halt_bug = !r_ime && w_irq_any;
`else
   assign w_halt_bug = 1'b0;
`endif

   always_comb begin
      w_lowest = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (bus.irq_pend[i]) w_lowest = IDX_W'(i);
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_ir_d        = r_ir;
      w_step_d      = r_step;
      w_prefix_d    = r_prefix;
      w_idx_d       = r_idx;
      w_ack_d       = '0;
      w_ime_d       = r_ime;
      w_ime_pend_d  = r_ime_pend;
      w_no_pc_inc_d = r_no_pc_inc;
      if (bus.mem_ready) begin
         w_no_pc_inc_d = 1'b0;
         if (r_state == SEQ_HALT) begin
            if (w_irq_any && r_ime) begin
               w_state_d = SEQ_IRQ;
               w_ime_d   = 1'b0;
               w_idx_d   = w_lowest;
               w_ack_d   = NUM_IRQ'(1) << w_lowest;
            end else if (w_irq_any) begin
               w_ir_d    = bus.d_in;
               w_state_d = SEQ_RUN;
            end
         end else begin
            if (bus.done) begin
               w_step_d   = '0;
               w_prefix_d = 1'b0;
               if (r_ime && w_irq_any && !w_in_irq) begin
                  w_state_d = SEQ_IRQ;
                  w_ime_d   = 1'b0;
                  w_idx_d   = w_lowest;
                  w_ack_d   = NUM_IRQ'(1) << w_lowest;
               end else if (bus.halt_req && !w_halt_bug) begin
                  w_state_d = SEQ_HALT;
               end else begin
                  w_ir_d        = bus.d_in;
                  w_state_d     = SEQ_RUN;
                  w_no_pc_inc_d = bus.halt_req;
               end
               // EI takes effect only after this edge's interrupt check
               if (r_ime_pend) begin
                  w_ime_d      = 1'b1;
                  w_ime_pend_d = 1'b0;
               end
            end else if (w_prefix_hit) begin
               w_ir_d     = bus.d_in;
               w_prefix_d = 1'b1;
               w_step_d   = '0;
            end else if (w_branch) begin
               w_step_d = bus.next_cond;
            end else begin
               w_step_d = r_step + 1'b1;
            end
            if (bus.ei_req) w_ime_pend_d = 1'b1;
            if (bus.di_req) begin
               w_ime_d      = 1'b0;
               w_ime_pend_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SEQ_RUN;
         r_ir        <= RESET_IR;
         r_step      <= '0;
         r_prefix    <= 1'b0;
         r_idx       <= '0;
         r_ack       <= '0;
         r_ime       <= 1'b0;
         r_ime_pend  <= 1'b0;
         r_no_pc_inc <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_ir        <= w_ir_d;
         r_step      <= w_step_d;
         r_prefix    <= w_prefix_d;
         r_idx       <= w_idx_d;
         r_ack       <= w_ack_d;
         r_ime       <= w_ime_d;
         r_ime_pend  <= w_ime_pend_d;
         r_no_pc_inc <= w_no_pc_inc_d;
      end
   end

   assign bus.ir        = r_ir;
   assign bus.in_prefix = r_prefix;
   assign bus.in_irq    = w_in_irq;
   assign bus.irq_idx   = r_idx;
   assign bus.irq_ack   = r_ack;
   assign bus.step      = r_step;
   assign bus.halted    = (r_state == SEQ_HALT);
   assign bus.ime       = r_ime;
   assign bus.no_pc_inc = r_no_pc_inc;

`ifndef SYNTHESIS
   logic w_step_wrap;
   assign w_step_wrap = bus.mem_ready && (r_state != SEQ_HALT) && !bus.done && !w_prefix_hit &&
                        !w_branch && (&r_step);

   a_step_wrap: assert property (@(posedge clk) disable iff (!rst_n) !w_step_wrap)
      else $error("op_sequencer: step counter wrapped without done");
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Self-checking bench for op_sequencer: directed scenarios plus randomized traffic
// against a behavioural instruction-level model.
module tb_op_sequencer;
   import seq_pkg::*;

   localparam int unsigned STEP_W  = 3;
   localparam int unsigned NUM_IRQ = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   op_sequencer_if #(.STEP_W(STEP_W), .NUM_IRQ(NUM_IRQ)) bus ();

   op_sequencer #(.STEP_W(STEP_W), .NUM_IRQ(NUM_IRQ), .RESET_IR(8'h00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [7:0] m_ir;
   logic [2:0] m_step, m_idx;
   logic [4:0] m_ack;
   bit         m_prefix, m_in_irq, m_halted, m_ime, m_pend, m_npi;

   function automatic logic [23:0] dut_vec();
      return {bus.ir, bus.in_prefix, bus.in_irq, bus.irq_idx, bus.irq_ack, bus.step,
              bus.halted, bus.ime, bus.no_pc_inc};
   endfunction

   function automatic logic [23:0] mdl_vec();
      return {m_ir, m_prefix, m_in_irq, m_idx, m_ack, m_step, m_halted, m_ime, m_npi};
   endfunction

   task automatic model_reset();
      m_ir = 8'h00; m_step = '0; m_idx = '0; m_ack = '0;
      m_prefix = 0; m_in_irq = 0; m_halted = 0; m_ime = 0; m_pend = 0; m_npi = 0;
   endtask

   task automatic model_dispatch();
      int k = 0;
      while (k < NUM_IRQ && !bus.irq_pend[k]) k++;
      m_idx = 3'(k); m_ack = 5'(1 << k); m_in_irq = 1; m_ime = 0;
   endtask

   // One clock edge of architectural behaviour, using the inputs currently applied.
   task automatic model_edge();
      bit was_ime, was_pend, was_irq, bug, flag, hit;
      logic [3:0] f;
      m_ack = '0;
      if (!bus.mem_ready) return;
      m_npi = 0;
      was_ime = m_ime; was_pend = m_pend; was_irq = m_in_irq;
      if (m_halted) begin
         if (bus.irq_pend != 0) begin
            m_halted = 0;
            if (was_ime) model_dispatch(); else m_ir = bus.d_in;
         end
         return;
      end
      if (bus.done) begin
         m_step = 0; m_prefix = 0; m_in_irq = 0;
         bug = 0;
`ifdef SEQ_HALT_BUG_EN
         bug = !was_ime && (bus.irq_pend != 0);
`endif
         if (was_ime && bus.irq_pend != 0 && !was_irq) model_dispatch();
         else if (bus.halt_req && !bug) m_halted = 1;
         else begin m_ir = bus.d_in; m_npi = bus.halt_req; end
         if (was_pend) begin m_ime = 1; m_pend = 0; end
      end else if (m_ir == 8'hCB && !m_prefix && !m_in_irq) begin
         m_ir = bus.d_in; m_prefix = 1; m_step = 0;
      end else begin
         f = bus.flags;
         flag = bus.cond[1] ? f[0] : f[3];
         hit = bus.cond[0] ? flag : !flag;
         if (bus.is_cond && !hit) m_step = bus.next_cond;
         else m_step = 3'((int'(m_step) + 1) % 8);
      end
      if (bus.ei_req) m_pend = 1;
      if (bus.di_req) begin m_ime = 0; m_pend = 0; end
   endtask

   task automatic idle_inputs();
      bus.done = 0; bus.is_cond = 0; bus.cond = COND_NZ; bus.flags = flags_t'(4'h0);
      bus.next_cond = '0; bus.halt_req = 0; bus.ei_req = 0; bus.di_req = 0;
      bus.mem_ready = 1; bus.d_in = 8'h00; bus.irq_pend = '0;
   endtask

   task automatic step_clk();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.ir !== 8'h00) begin n_bad++; $display("FAIL reset_ir got %h want 00", bus.ir); end
      n_cmp++; if (bus.step !== 3'd0) begin n_bad++; $display("FAIL reset_step got %0d want 0", bus.step); end
      n_cmp++; if ({bus.in_prefix, bus.in_irq, bus.halted, bus.ime, bus.no_pc_inc} !== 5'b0) begin
         n_bad++; $display("FAIL reset_flags got %b want 00000",
                           {bus.in_prefix, bus.in_irq, bus.halted, bus.ime, bus.no_pc_inc});
      end
      n_cmp++; if ({bus.irq_idx, bus.irq_ack} !== 8'h00) begin
         n_bad++; $display("FAIL reset_irq got %h want 00", {bus.irq_idx, bus.irq_ack});
      end
      rst_n = 1;
   endtask

   task automatic test_nop_stream();
      idle_inputs();
      bus.done = 1;
      for (int i = 0; i < 4; i++) begin
         step_clk();
         n_cmp++; if (bus.step !== 3'd0) begin n_bad++; $display("FAIL nop_step got %0d want 0", bus.step); end
         n_cmp++; if (bus.ir !== 8'h00) begin n_bad++; $display("FAIL nop_ir got %h want 00", bus.ir); end
      end
      bus.d_in = 8'h3C; step_clk();
      bus.done = 0; step_clk();
      n_cmp++; if (bus.step !== 3'd1) begin n_bad++; $display("FAIL pre_rst_step got %0d want 1", bus.step); end
      #2 rst_n = 0;
      #1;
      n_cmp++; if (dut_vec() !== 24'h0) begin n_bad++; $display("FAIL midrun_reset got %h want 000000", dut_vec()); end
      model_reset();
      #1 rst_n = 1;
      idle_inputs(); bus.done = 1;
      step_clk();
   endtask

   task automatic test_jr();
      idle_inputs();
      bus.done = 1; bus.d_in = 8'h20; step_clk();
      n_cmp++; if (bus.ir !== 8'h20) begin n_bad++; $display("FAIL jr_fetch got %h want 20", bus.ir); end
      bus.done = 0; bus.is_cond = 1; bus.cond = COND_NZ; bus.flags = flags_t'(4'b1000);
      bus.next_cond = 3'd3; step_clk();
      n_cmp++; if (bus.step !== 3'd3) begin n_bad++; $display("FAIL jr_skip got %0d want 3", bus.step); end
      bus.is_cond = 0; bus.done = 1; bus.d_in = 8'h00; step_clk();
      n_cmp++; if (bus.ir !== 8'h00 || bus.step !== 3'd0) begin
         n_bad++; $display("FAIL jr_done got ir=%h step=%0d want 00/0", bus.ir, bus.step);
      end
      bus.d_in = 8'h20; step_clk();
      bus.done = 0; bus.is_cond = 1; bus.flags = flags_t'(4'b0000); step_clk();
      n_cmp++; if (bus.step !== 3'd1) begin n_bad++; $display("FAIL jr_taken1 got %0d want 1", bus.step); end
      bus.is_cond = 0; step_clk();
      n_cmp++; if (bus.step !== 3'd2) begin n_bad++; $display("FAIL jr_taken2 got %0d want 2", bus.step); end
      bus.done = 1; bus.d_in = 8'h00; step_clk();
   endtask

   task automatic test_prefix();
      idle_inputs();
      bus.done = 1; bus.d_in = 8'hCB; step_clk();
      bus.done = 0; bus.d_in = 8'h11; step_clk();
      n_cmp++; if ({bus.ir, bus.in_prefix, bus.step} !== {8'h11, 1'b1, 3'd0}) begin
         n_bad++; $display("FAIL cb_load got ir=%h pfx=%b step=%0d want 11/1/0",
                           bus.ir, bus.in_prefix, bus.step);
      end
      step_clk();
      n_cmp++; if (bus.step !== 3'd1) begin n_bad++; $display("FAIL cb_step got %0d want 1", bus.step); end
      bus.done = 1; bus.d_in = 8'h00; step_clk();
      n_cmp++; if (bus.in_prefix !== 1'b0) begin n_bad++; $display("FAIL cb_clear got %b want 0", bus.in_prefix); end
   endtask

   task automatic test_stall();
      bit exp_ime;
      idle_inputs();
      bus.done = 1; step_clk();
      bus.done = 0; step_clk();
      exp_ime = m_ime;
      bus.mem_ready = 0; bus.done = 1; bus.d_in = 8'h55; bus.irq_pend = 5'b00001;
      for (int i = 0; i < 3; i++) begin
         step_clk();
         n_cmp++; if ({bus.step, bus.ir, bus.ime, bus.irq_ack} !== {3'd1, 8'h00, exp_ime, 5'b0}) begin
            n_bad++; $display("FAIL stall got step=%0d ir=%h ime=%b ack=%b want 1/00/%b/00000",
                              bus.step, bus.ir, bus.ime, bus.irq_ack, exp_ime);
         end
      end
      idle_inputs(); bus.done = 1; step_clk();
   endtask

   task automatic test_ei_irq();
      idle_inputs();
      bus.done = 1; bus.d_in = 8'hFB; step_clk();
      bus.ei_req = 1; bus.d_in = 8'h00; bus.irq_pend = 5'b00110; step_clk();
      n_cmp++; if ({bus.ime, bus.in_irq, bus.irq_ack} !== 7'b0) begin
         n_bad++; $display("FAIL ei_edge got ime=%b irq=%b ack=%b want 0/0/0", bus.ime, bus.in_irq, bus.irq_ack);
      end
      bus.ei_req = 0; step_clk();
      n_cmp++; if ({bus.ime, bus.in_irq, bus.irq_ack} !== {1'b1, 1'b0, 5'b0}) begin
         n_bad++; $display("FAIL ei_nop got ime=%b irq=%b ack=%b want 1/0/0", bus.ime, bus.in_irq, bus.irq_ack);
      end
      step_clk();
      n_cmp++; if ({bus.in_irq, bus.irq_idx, bus.irq_ack, bus.ime, bus.ir} !== {1'b1, 3'd1, 5'b00010, 1'b0, 8'h00}) begin
         n_bad++; $display("FAIL dispatch got irq=%b idx=%0d ack=%b ime=%b ir=%h want 1/1/00010/0/00",
                           bus.in_irq, bus.irq_idx, bus.irq_ack, bus.ime, bus.ir);
      end
      bus.done = 0; step_clk();
      n_cmp++; if (bus.irq_ack !== 5'b0 || bus.in_irq !== 1'b1) begin
         n_bad++; $display("FAIL ack_pulse got ack=%b irq=%b want 00000/1", bus.irq_ack, bus.in_irq);
      end
      bus.done = 1; bus.irq_pend = '0; step_clk();
      n_cmp++; if (bus.in_irq !== 1'b0) begin n_bad++; $display("FAIL isr_exit got %b want 0", bus.in_irq); end
   endtask

   task automatic test_halt();
      idle_inputs();
      bus.done = 1; bus.d_in = 8'h76; step_clk();
      bus.halt_req = 1; bus.d_in = 8'h00; step_clk();
      n_cmp++; if ({bus.halted, bus.step, bus.ir} !== {1'b1, 3'd0, 8'h76}) begin
         n_bad++; $display("FAIL halt_enter got h=%b step=%0d ir=%h want 1/0/76", bus.halted, bus.step, bus.ir);
      end
      bus.halt_req = 0; bus.done = 0; bus.is_cond = 1; bus.next_cond = 3'd5;
      repeat (2) step_clk();
      n_cmp++; if (bus.halted !== 1'b1 || bus.step !== 3'd0) begin
         n_bad++; $display("FAIL halt_hold got h=%b step=%0d want 1/0", bus.halted, bus.step);
      end
      bus.is_cond = 0; bus.irq_pend = 5'b10000; bus.d_in = 8'h3E; step_clk();
      n_cmp++; if ({bus.halted, bus.ir, bus.in_irq, bus.irq_ack} !== {1'b0, 8'h3E, 1'b0, 5'b0}) begin
         n_bad++; $display("FAIL halt_wake got h=%b ir=%h irq=%b ack=%b want 0/3E/0/00000",
                           bus.halted, bus.ir, bus.in_irq, bus.irq_ack);
      end
      idle_inputs(); bus.done = 1; step_clk();
      // HALT with an interrupt already pending and IME clear
      bus.d_in = 8'h76; step_clk();
      bus.halt_req = 1; bus.irq_pend = 5'b00001; bus.d_in = 8'h04; step_clk();
`ifdef SEQ_HALT_BUG_EN
      n_cmp++; if ({bus.halted, bus.ir, bus.no_pc_inc} !== {1'b0, 8'h04, 1'b1}) begin
         n_bad++; $display("FAIL halt_bug got h=%b ir=%h npi=%b want 0/04/1", bus.halted, bus.ir, bus.no_pc_inc);
      end
`else
      n_cmp++; if ({bus.halted, bus.ir, bus.no_pc_inc} !== {1'b1, 8'h76, 1'b0}) begin
         n_bad++; $display("FAIL halt_nobug got h=%b ir=%h npi=%b want 1/76/0", bus.halted, bus.ir, bus.no_pc_inc);
      end
`endif
      bus.halt_req = 0; bus.done = 0; step_clk();
      n_cmp++; if ({bus.halted, bus.ir, bus.no_pc_inc} !== {1'b0, 8'h04, 1'b0}) begin
         n_bad++; $display("FAIL halt_after got h=%b ir=%h npi=%b want 0/04/0", bus.halted, bus.ir, bus.no_pc_inc);
      end
      idle_inputs(); bus.done = 1; step_clk();
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         bus.mem_ready = ($urandom_range(0, 7) != 0);
         bus.done      = (m_step == 3'd7) || ($urandom_range(0, 2) == 0);
         bus.is_cond   = 1'($urandom_range(0, 1));
         bus.cond      = cond_t'(2'($urandom_range(0, 3)));
         bus.flags     = flags_t'(4'($urandom_range(0, 15)));
         bus.next_cond = 3'($urandom_range(0, 7));
         bus.halt_req  = bus.done && ($urandom_range(0, 9) == 0);
         bus.ei_req    = bus.done && ($urandom_range(0, 5) == 0);
         bus.di_req    = bus.done && ($urandom_range(0, 11) == 0);
         bus.d_in      = ($urandom_range(0, 5) == 0) ? 8'hCB : 8'($urandom);
         bus.irq_pend  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
         step_clk();
         n_cmp++; if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL random cycle %0d got %h want %h", n, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_nop_stream();
      test_jr();
      test_prefix();
      test_stall();
      test_ei_irq();
      test_halt();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
